// File: rtl/square_pkg.sv
// Shared constants and helpers for the square arbiter slice.
// Optional result saturation flag is enabled with SQUARE_ARBITER_SAT_FLAG_EN.
package square_pkg;

  // Pipeline depth of the square datapath; the id tag pipe must match it.
  localparam int SQ_LATENCY = 2;

  // Width of a requester index; a two-requester arbiter still needs one bit.
  function automatic int calc_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/square.sv
// Shared square datapath: clamp the operand magnitude, then square it.
// Two register stages (SQ_LATENCY). With SQUARE_ARBITER_SAT_FLAG_EN the
// saturation decision travels alongside the result.
module square
  import square_pkg::*;
#(
  parameter int VALUE_WIDTH = 12,
  parameter int VALUE_MAX   = 1500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [VALUE_WIDTH-1:0]       in_value,
  output logic                         out_valid,
  output logic [(VALUE_WIDTH-1)*2-1:0] out_data
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
  ,
  output logic                         out_sat
`endif
);

  localparam int MAG_W = VALUE_WIDTH - 1;
  localparam int RES_W = MAG_W * 2;

  logic [VALUE_WIDTH-1:0] abs_value;
  logic                   sat_now;
  logic [MAG_W-1:0]       clamp_mag;
  logic                   s1_valid;
  logic [MAG_W-1:0]       s1_mag;
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
  logic                   s1_sat;
`endif

  // Magnitude as an unsigned W-bit value; the most negative input maps to
  // 2^(W-1), which is above any legal VALUE_MAX and so saturates naturally.
  always_comb begin
    abs_value = in_value[VALUE_WIDTH-1] ? (~in_value + VALUE_WIDTH'(1)) : in_value;
    sat_now   = (abs_value > VALUE_WIDTH'(VALUE_MAX));
    clamp_mag = sat_now ? MAG_W'(VALUE_MAX) : abs_value[MAG_W-1:0];
  end

  // Valid pipeline; cleared by reset so nothing in flight survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // Data pipeline: stage 1 holds the clamped magnitude, stage 2 its square.
  always_ff @(posedge clk) begin
    s1_mag   <= clamp_mag;
    out_data <= RES_W'(s1_mag) * RES_W'(s1_mag);
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
    s1_sat   <= sat_now;
    out_sat  <= s1_sat;
`endif
  end

endmodule

// File: rtl/square_arbiter.sv
// Round-robin arbiter feeding one shared square unit, with a credit-guarded
// first-word-fall-through result FIFO and an id tag pipe.
// Define SQUARE_ARBITER_SAT_FLAG_EN to add the per-entry res_sat output.
module square_arbiter
  import square_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int VALUE_WIDTH = 12,
  parameter int VALUE_MAX   = 1500,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*VALUE_WIDTH-1:0]      req_value,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [(VALUE_WIDTH-1)*2-1:0]      res_data,
  output logic [calc_id_width(N_REQ)-1:0]   res_id,
  output logic                              res_valid,
  input  logic                              res_ready
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
  ,
  output logic                              res_sat
`endif
);

  localparam int ID_W  = calc_id_width(N_REQ);
  localparam int RES_W = (VALUE_WIDTH - 1) * 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]        prio_ptr;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        scan_idx;
  logic                   grant_any;
  logic                   credit_ok;
  logic [VALUE_WIDTH-1:0] sel_value;

  logic                   op_valid;
  logic [VALUE_WIDTH-1:0] op_value;
  logic [ID_W-1:0]        op_id;
  logic [ID_W-1:0]        tag_pipe [SQ_LATENCY];

  logic                   sq_out_valid;
  logic [RES_W-1:0]       sq_out_data;
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
  logic                   sq_out_sat;
  logic                   mem_sat  [FIFO_DEPTH];
`endif

  logic [CNT_W-1:0]       in_flight;
  logic [CNT_W-1:0]       fifo_count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [RES_W-1:0]       mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]        mem_id   [FIFO_DEPTH];
  logic                   push;
  logic                   pop;

  // A grant is only issued when every accepted operand is guaranteed a slot.
  always_comb begin
    credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < (CNT_W + 1)'(FIFO_DEPTH);
  end

  // Round-robin search starting at the priority pointer; first valid wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (!reset && credit_ok) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = ID_W'((int'(prio_ptr) + k) % N_REQ);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any       = 1'b1;
          grant_idx       = scan_idx;
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  // Select the granted requester's operand.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_value = req_value[i*VALUE_WIDTH +: VALUE_WIDTH];
      end
    end
  end

  // Priority pointer and operand-valid register; pointer moves past the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_ptr <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= grant_any;
      if (grant_any) begin
        prio_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  // Capture the accepted operand and its requester id.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      op_value <= sel_value;
      op_id    <= grant_idx;
    end
  end

  // Tag pipe shifts every cycle in lockstep with the square unit stages.
  always_ff @(posedge clk) begin
    tag_pipe[0] <= op_id;
    for (int s = 1; s < SQ_LATENCY; s++) begin
      tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  square #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .VALUE_MAX   (VALUE_MAX)
  ) u_square (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (op_valid),
    .in_value  (op_value),
    .out_valid (sq_out_valid),
    .out_data  (sq_out_data)
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
    ,
    .out_sat   (sq_out_sat)
`endif
  );

  assign push = sq_out_valid;
  assign pop  = res_valid & res_ready;

  // Credit bookkeeping and FIFO pointers; pointers wrap at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      in_flight  <= in_flight + CNT_W'(grant_any) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage write; space is always available thanks to the credit check.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= sq_out_data;
      mem_id[wr_ptr]   <= tag_pipe[SQ_LATENCY-1];
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
      mem_sat[wr_ptr]  <= sq_out_sat;
`endif
    end
  end

  // Head of the FIFO falls through; outputs read as zero while empty.
  always_comb begin
    res_valid = (fifo_count != '0);
    res_data  = res_valid ? mem_data[rd_ptr] : '0;
    res_id    = res_valid ? mem_id[rd_ptr]   : '0;
`ifdef SQUARE_ARBITER_SAT_FLAG_EN
    res_sat   = res_valid ? mem_sat[rd_ptr]  : 1'b0;
`endif
  end

endmodule

// File: doc/square_arbiter.md
SQUARE_ARBITER -- requirements
Module: square_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter VALUE_WIDTH, default 12, signed operand width.
REQ-003 SHALL have parameter VALUE_MAX, default 1500, largest magnitude squared exactly.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of 2, at least 4).
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, N_REQ, one request bit per requester.
REQ-008 SHALL have port req_value, input, N_REQ*VALUE_WIDTH, signed operand per requester; requester i occupies bits [i*VALUE_WIDTH +: VALUE_WIDTH].
REQ-009 SHALL have port req_ready, output, N_REQ, one-hot grant; combinational from req_valid, priority pointer and credit.
REQ-010 SHALL have port res_data, output, (VALUE_WIDTH-1)*2, square result.
REQ-011 SHALL have port res_id, output, clog2(N_REQ), requester index of res_data.
REQ-012 SHALL have port res_valid, output, 1, result present.
REQ-013 SHALL have port res_ready, input, 1, consumer accepts the result.

Function
REQ-014 SHALL accept a request from requester i on an edge where req_valid[i] & req_ready[i]; at most one acceptance per cycle.
REQ-015 SHALL arbitrate round-robin: the search starts at pointer p; after a grant to i, p becomes (i+1) mod N_REQ; p is unchanged when nothing is granted.
REQ-016 SHALL grant only when credit is available: fifo_count + in_flight < FIFO_DEPTH, where in_flight counts accepted operands not yet written to the FIFO.
REQ-017 SHALL compute the result through one square sub-unit with 2-cycle latency: operand and id are registered on acceptance (cycle t); data_valid is presented at t+1; the result is written to the FIFO at t+3; the entry is visible on res_* at t+4 at the earliest.
REQ-018 SHALL carry the id through a tag pipeline matched to the sub-unit latency; id and result SHALL never be misaligned.
REQ-019 SHALL saturate the operand magnitude: |value| > VALUE_MAX yields VALUE_MAX*VALUE_MAX; value -2^(VALUE_WIDTH-1) SHALL also saturate.
REQ-020 SHALL implement a first-word-fall-through FIFO: res_valid = (count != 0); pop on res_valid & res_ready; read and write pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged and keep data order.
REQ-022 SHALL never overflow the FIFO; the credit rule guarantees space, so no write is dropped.
REQ-023 SHALL keep res_data and res_id stable while res_valid & !res_ready.

Reset
REQ-024 SHALL, while reset is high, clear p to 0, in_flight to 0, the FIFO count and pointers to 0, and the sub-unit valid pipeline; req_ready = 0, res_valid = 0, res_data = 0, res_id = 0.
REQ-025 SHALL discard operations in flight when reset is asserted mid-operation; no result from before reset SHALL appear afterwards.

Configuration
REQ-026 SHALL recognise macro SQUARE_ARBITER_SAT_FLAG_EN.
REQ-027 SHALL, with the macro defined, add output res_sat (1 bit), stored per FIFO entry, set when the operand saturated under REQ-019, reset value 0.
REQ-028 SHALL, without the macro, have no res_sat port and no flag storage; all other behaviour is identical.

Structure
REQ-029 SHALL place the id-width function/constant and the latency constant SQ_LATENCY=2 in package square_pkg.
REQ-030 SHALL instantiate one sub-module, square, as the shared datapath; the FIFO, arbiter and tag pipe are inline.

Verification
REQ-031 Single request: req_valid=0001 and value=-3 accepted at t -> res_valid at t+4 with res_data=9, res_id=0.
REQ-032 Round-robin: req_valid=1111 held, res_ready=1 -> grants in order 0,1,2,3,0; one result per cycle after the pipe fills.
REQ-033 Backpressure: res_ready=0 with all requesters active -> exactly FIFO_DEPTH acceptances, then req_ready=0; after one pop, exactly one more grant.
REQ-034 Saturation: value=2000, then value=-2048 -> res_data=2250000 for both; res_sat=1 with the macro defined.
REQ-035 Simultaneous push/pop at count=FIFO_DEPTH-1 -> count unchanged, order preserved.
REQ-036 Reset with 3 operations in flight -> res_valid=0 afterwards and the next request's result returns with the correct id.
